// File: rtl/direction_queue_pkg.sv
// ----------------------------------------------------------------------------
// snake_pkg
//   Shared definitions for the snake game datapath.
//   The direction encoding and the opposite() helper are reused by the turn
//   queue, the collision logic and the renderer.
//   Encoding: 0 = UP, 1 = DOWN, 2 = LEFT, 3 = RIGHT. Opposites differ in bit 0.
// ----------------------------------------------------------------------------
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/direction_queue_if.sv
// ----------------------------------------------------------------------------
// direction_queue_if
//   Bundles the button/tick/clear requests going into the turn queue and the
//   heading/status coming out of it.
//   master : game/debouncer side (drives requests, observes heading)
//   slave  : direction_queue (consumes requests, drives heading)
//   Signals:
//     Clear                        - synchronous flush for game restart
//     BtnUp/BtnDown/BtnLeft/BtnRight - one-cycle debounced button pulses
//     Tick                         - one-cycle game-step strobe
//     Direction                    - current heading
//     Turned                       - one-cycle pulse after Direction changed
//     Rejected                     - one-cycle pulse after a dropped request
//     Count                        - number of queued turns
// ----------------------------------------------------------------------------
interface direction_queue_if
    import snake_pkg::*;
#(
    parameter int DEPTH = 2
) ();

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             Clear;
    logic             BtnUp;
    logic             BtnDown;
    logic             BtnLeft;
    logic             BtnRight;
    logic             Tick;
    dir_t             Direction;
    logic             Turned;
    logic             Rejected;
    logic [CNT_W-1:0] Count;

    modport master (
        output Clear, BtnUp, BtnDown, BtnLeft, BtnRight, Tick,
        input  Direction, Turned, Rejected, Count
    );

    modport slave (
        input  Clear, BtnUp, BtnDown, BtnLeft, BtnRight, Tick,
        output Direction, Turned, Rejected, Count
    );

endinterface

// File: rtl/direction_queue_turn_fifo.sv
// ----------------------------------------------------------------------------
// turn_fifo
//   DEPTH x 2-bit synchronous circular FIFO holding pending turns.
//   Ports:
//     clk, rst_n   - clock, synchronous active-low reset
//     flush        - synchronous empty (game restart)
//     push, push_data
//     pop
//     head         - oldest entry (valid when !empty)
//     tail         - newest entry (valid when !empty)
//     count, full, empty
//   A push while full is dropped unless a pop happens in the same cycle; a pop
//   while empty is ignored, so count never leaves 0..DEPTH.
// ----------------------------------------------------------------------------
module turn_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  dir_t             push_data,
    input  logic             pop,
    output dir_t             head,
    output dir_t             tail,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int                 PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]   PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEPTH);

    dir_t             mem_q [DEPTH];
    dir_t             mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] tail_idx;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_MAX);
    assign count    = count_q;
    assign head     = mem_q[rd_ptr_q];
    // Newest entry sits one slot behind the write pointer, wrapping at 0.
    assign tail_idx = (wr_ptr_q == '0) ? PTR_MAX : wr_ptr_q - 1'b1;
    assign tail     = mem_q[tail_idx];

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/direction_queue.sv
// ----------------------------------------------------------------------------
// direction_queue
//   Buffers player turn requests between the button debouncers and the
//   game-step logic. Illegal (reversal) and redundant (same heading) requests
//   are dropped; up to DEPTH legal turns are queued and one is applied to the
//   heading per game Tick.
//   Ports:
//     Clock    - system clock
//     Reset_n  - synchronous active-low reset
//     bus      - direction_queue_if.slave (buttons, Tick, Clear in;
//                Direction, Turned, Rejected, Count out)
//   All outputs are registered.
// ----------------------------------------------------------------------------
module direction_queue
    import snake_pkg::*;
#(
    parameter int   DEPTH    = 2,
    parameter dir_t INIT_DIR = 2'd3
) (
    input  logic              Clock,
    input  logic              Reset_n,
    direction_queue_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    dir_t             dir_q, dir_d;
    logic             turned_q, turned_d;
    logic             rejected_q, rejected_d;

    logic             sel_vld;
    dir_t             sel_dir;
    dir_t             ref_dir;
    logic             accept;
    logic             fifo_push;
    logic             fifo_pop;
    dir_t             fifo_head;
    dir_t             fifo_tail;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    turn_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_turn_fifo (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .flush     (bus.Clear),
        .push      (fifo_push),
        .push_data (sel_dir),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .tail      (fifo_tail),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        // Only the highest-priority button is considered; the rest vanish.
        sel_vld = bus.BtnUp || bus.BtnDown || bus.BtnLeft || bus.BtnRight;
        if (bus.BtnUp) begin
            sel_dir = DIR_UP;
        end else if (bus.BtnDown) begin
            sel_dir = DIR_DOWN;
        end else if (bus.BtnLeft) begin
            sel_dir = DIR_LEFT;
        end else begin
            sel_dir = DIR_RIGHT;
        end

        // A new turn is judged against the heading the snake will have when
        // it is applied: the newest queued turn, or the live heading.
        ref_dir = fifo_empty ? dir_q : fifo_tail;

        // A full queue still accepts when the same-cycle Tick frees a slot.
        accept = sel_vld
              && (sel_dir != ref_dir)
              && (sel_dir != opposite(ref_dir))
              && (!fifo_full || bus.Tick);

        fifo_push = accept && !bus.Clear;
        fifo_pop  = bus.Tick && !bus.Clear;

        dir_d      = dir_q;
        turned_d   = 1'b0;
        rejected_d = 1'b0;

        if (bus.Clear) begin
            dir_d = INIT_DIR;
        end else begin
            // A queued turn always differs from the heading it follows, so
            // every pop is a real change of direction.
            if (bus.Tick && !fifo_empty) begin
                dir_d    = fifo_head;
                turned_d = 1'b1;
            end
            rejected_d = sel_vld && !accept;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            dir_q      <= INIT_DIR;
            turned_q   <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            turned_q   <= turned_d;
            rejected_q <= rejected_d;
        end
    end

    assign bus.Direction = dir_q;
    assign bus.Turned    = turned_q;
    assign bus.Rejected  = rejected_q;
    assign bus.Count     = fifo_count;

endmodule

// File: tb/tb_direction_queue.sv
// ----------------------------------------------------------------------------
// tb_direction_queue
//   Directed bench for direction_queue (DEPTH = 2, INIT_DIR = RIGHT).
//   Each step drives one cycle of inputs and queues the outputs expected
//   after the following rising edge; the entry is popped and compared once
//   that edge has passed.
// ----------------------------------------------------------------------------
module tb_direction_queue;
    import snake_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        string            tag;
        dir_t             dir;
        logic             turned;
        logic             rejected;
        logic [CNT_W-1:0] count;
    } exp_t;

    logic Clock;
    logic Reset_n;
    int   errors;
    int   checks;
    exp_t sb [$];

    direction_queue_if #(.DEPTH(DEPTH)) bus ();

    direction_queue #(
        .DEPTH    (DEPTH),
        .INIT_DIR (2'd3)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running required=done");
        $fatal(1, "timeout");
    end

    // btn = {up, down, left, right}
    task automatic step(input string tag, input logic [3:0] btn, input logic tick,
                        input logic clr, input logic rst_n,
                        input dir_t e_dir, input logic e_turn, input logic e_rej,
                        input int e_cnt);
        exp_t e;
        exp_t got;
        @(negedge Clock);
        Reset_n      = rst_n;
        bus.BtnUp    = btn[3];
        bus.BtnDown  = btn[2];
        bus.BtnLeft  = btn[1];
        bus.BtnRight = btn[0];
        bus.Tick     = tick;
        bus.Clear    = clr;
        e.tag      = tag;
        e.dir      = e_dir;
        e.turned   = e_turn;
        e.rejected = e_rej;
        e.count    = CNT_W'(e_cnt);
        sb.push_back(e);
        @(posedge Clock);
        #1;
        got = sb.pop_front();
        checks++;
        assert (bus.Direction === got.dir) else begin
            errors++;
            $error("FAIL %s.dir observed=%0d expected=%0d", got.tag, bus.Direction, got.dir);
        end
        checks++;
        assert (bus.Turned === got.turned) else begin
            errors++;
            $error("FAIL %s.turned observed=%b expected=%b", got.tag, bus.Turned, got.turned);
        end
        checks++;
        assert (bus.Rejected === got.rejected) else begin
            errors++;
            $error("FAIL %s.rejected observed=%b expected=%b", got.tag, bus.Rejected, got.rejected);
        end
        checks++;
        assert (bus.Count === got.count) else begin
            errors++;
            $error("FAIL %s.count observed=%0d expected=%0d", got.tag, bus.Count, got.count);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        Reset_n      = 1'b0;
        bus.BtnUp    = 1'b0;
        bus.BtnDown  = 1'b0;
        bus.BtnLeft  = 1'b0;
        bus.BtnRight = 1'b0;
        bus.Tick     = 1'b0;
        bus.Clear    = 1'b0;

        // Reset held 3 cycles while buttons/tick pulse
        step("rst0", 4'b1000, 1'b0, 1'b0, 1'b0, DIR_RIGHT, 0, 0, 0);
        step("rst1", 4'b1000, 1'b1, 1'b0, 1'b0, DIR_RIGHT, 0, 0, 0);
        step("rst2", 4'b0110, 1'b1, 1'b0, 1'b0, DIR_RIGHT, 0, 0, 0);
        step("idle", 4'b0000, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 0);

        // Two queued turns: UP then LEFT
        step("q_up",    4'b1000, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 1);
        step("q_idle",  4'b0000, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 1);
        step("q_left",  4'b0010, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 2);
        step("q_hold",  4'b0000, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 2);
        step("q_tick1", 4'b0000, 1'b1, 1'b0, 1'b1, DIR_UP,    1, 0, 1);
        step("q_nostk", 4'b0000, 1'b0, 1'b0, 1'b1, DIR_UP,    0, 0, 1);
        step("q_tick2", 4'b0000, 1'b1, 1'b0, 1'b1, DIR_LEFT,  1, 0, 0);
        step("q_tickE", 4'b0000, 1'b1, 1'b0, 1'b1, DIR_LEFT,  0, 0, 0);

        // Clear back to RIGHT, then reversal / duplicate rejects
        step("clr1",    4'b0000, 1'b0, 1'b1, 1'b1, DIR_RIGHT, 0, 0, 0);
        step("rj_rev",  4'b0010, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 1, 0);
        step("rj_nstk", 4'b0000, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 0);
        step("rj_same", 4'b0001, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 1, 0);
        step("rj_up1",  4'b1000, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 1);
        step("rj_up2",  4'b1000, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 1, 1);
        step("rj_down", 4'b0100, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 1, 1);

        // Full queue [UP, LEFT]
        step("f_left",  4'b0010, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 2);
        step("f_full",  4'b0100, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 1, 2);
        step("f_pp",    4'b0100, 1'b1, 1'b0, 1'b1, DIR_UP,    1, 0, 2);
        step("f_pop1",  4'b0000, 1'b1, 1'b0, 1'b1, DIR_LEFT,  1, 0, 1);
        step("f_pop2",  4'b0000, 1'b1, 1'b0, 1'b1, DIR_DOWN,  1, 0, 0);

        // Simultaneous buttons: DOWN beats LEFT, LEFT ignored silently
        step("clr2",    4'b0000, 1'b0, 1'b1, 1'b1, DIR_RIGHT, 0, 0, 0);
        step("s_dl",    4'b0110, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 1);
        step("s_tick",  4'b0000, 1'b1, 1'b0, 1'b1, DIR_DOWN,  1, 0, 0);
        // UP beats DOWN
        step("clr3",    4'b0000, 1'b0, 1'b1, 1'b1, DIR_RIGHT, 0, 0, 0);
        step("s_ud",    4'b1100, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 1);
        step("s_tick2", 4'b0000, 1'b1, 1'b0, 1'b1, DIR_UP,    1, 0, 0);

        // Push + pop with Count = 1: pushed entry becomes head
        step("clr4",    4'b0000, 1'b0, 1'b1, 1'b1, DIR_RIGHT, 0, 0, 0);
        step("p1_up",   4'b1000, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 1);
        step("p1_pp",   4'b0010, 1'b1, 1'b0, 1'b1, DIR_UP,    1, 0, 1);
        step("p1_pop",  4'b0000, 1'b1, 1'b0, 1'b1, DIR_LEFT,  1, 0, 0);

        // Push with Tick on empty queue: entry not popped that cycle
        step("clr5",    4'b0000, 1'b0, 1'b1, 1'b1, DIR_RIGHT, 0, 0, 0);
        step("e_pt",    4'b1000, 1'b1, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 1);
        step("e_pop",   4'b0000, 1'b1, 1'b0, 1'b1, DIR_UP,    1, 0, 0);

        // Pointer wrap: several fill/drain rounds
        step("w_down",  4'b0100, 1'b0, 1'b0, 1'b1, DIR_UP,    0, 1, 0);
        step("w_left",  4'b0010, 1'b0, 1'b0, 1'b1, DIR_UP,    0, 0, 1);
        step("w_down2", 4'b0100, 1'b0, 1'b0, 1'b1, DIR_UP,    0, 0, 2);
        step("w_pop1",  4'b0000, 1'b1, 1'b0, 1'b1, DIR_LEFT,  1, 0, 1);
        step("w_pp",    4'b0001, 1'b1, 1'b0, 1'b1, DIR_DOWN,  1, 0, 1);
        step("w_pop2",  4'b0000, 1'b1, 1'b0, 1'b1, DIR_RIGHT, 1, 0, 0);

        // Clear mid-operation with Count = 2, coincident Tick and button
        step("c_up",    4'b1000, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 1);
        step("c_left",  4'b0010, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 2);
        step("c_clr",   4'b0100, 1'b1, 1'b1, 1'b1, DIR_RIGHT, 0, 0, 0);
        step("c_after", 4'b0000, 1'b1, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 0);

        // Reset mid-operation overrides everything
        step("r_up",    4'b1000, 1'b0, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 1);
        step("r_rst",   4'b0010, 1'b1, 1'b0, 1'b0, DIR_RIGHT, 0, 0, 0);
        step("r_after", 4'b0000, 1'b1, 1'b0, 1'b1, DIR_RIGHT, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/direction_queue.md
# direction_queue

Buffers player turn requests between the four per-button debouncers and the game-step logic. Takes each debouncer's one-cycle `Enabled` pulse, drops turn requests that are illegal or redundant, and queues up to `DEPTH` legal turns. One queued turn is applied to the snake's heading on each game tick. This lets two quick presses inside one tick (e.g. up then left) both take effect, and never lets the snake reverse into itself.

## Interface
- `DEPTH`, 2: number of pending turns held; legal range 1–8.
- `INIT_DIR`, 2'd3: heading after reset or `Clear`.

- `Clock`  in  1  — system clock; all state updates on its rising edge.
- `Reset_n`  in  1  — synchronous, active-low reset.
- `Clear`  in  1  — synchronous flush for game restart; same effect as reset.
- `BtnUp`, `BtnDown`, `BtnLeft`, `BtnRight`  in  1 each  — single-cycle pulses from the debouncers.
- `Tick`  in  1  — single-cycle game-step strobe.
- `Direction`  out  2  — current heading: 0 = UP, 1 = DOWN, 2 = LEFT, 3 = RIGHT.
- `Turned`  out  1  — one-cycle pulse when `Direction` has just changed.
- `Rejected`  out  1  — one-cycle pulse when a button request was dropped.
- `Count`  out  $clog2(DEPTH+1)  — number of queued turns.

Reset is synchronous and active-low. Clock and reset ports are named `Clock` and `Reset_n`.

## Operation
- **Encoding.** The opposite of direction `d` is `d ^ 2'b01`.
- **Reset or `Clear`.** Either one flushes the queue:
  - `Count` = 0
  - `Direction` = `INIT_DIR`
  - `Turned` = 0, `Rejected` = 0
  - `Reset_n` low takes precedence over all other inputs. `Clear` high takes precedence over `Tick` and buttons.
- **Request selection.** If more than one button pulses in the same cycle, priority is Up > Down > Left > Right. Only one request is considered; the others are silently ignored (no `Rejected`).
- **Reference heading.** `ref` = queue tail if `Count` > 0, else `Direction`. The value is taken before any same-cycle pop.
- **Accept rule.** Accept request `r` iff all of the following hold:
  - `r != ref`
  - `r != ref ^ 1`
  - the queue is not full (`Count` < `DEPTH`), or `Tick` pops in the same cycle.
- **Reject.** Any considered request that fails the accept rule asserts `Rejected` on the next cycle. Reversal, duplicate and full-queue cases all count as rejects.
- **Pop.** On `Tick` with `Count` > 0:
  - `Direction` <= queue head
  - head is removed
  - `Turned` pulses next cycle
- **Tick with empty queue.** No change; no `Turned`.
- **Simultaneous push and pop.** Both happen in the same cycle.
  - `Count` is unchanged.
  - If `Count` was 1, the pushed entry becomes the new head.
- **Queue storage.** Circular buffer with read and write pointers that wrap modulo `DEPTH`. `Count` saturates at `DEPTH` and never underflows.

## Timing
- Push latency: a button pulse in cycle N is reflected in `Count` in cycle N+1.
- Pop latency: `Tick` in cycle N gives the new `Direction` and `Turned` = 1 in cycle N+1.
- A turn pushed in cycle N is poppable by a `Tick` in cycle N+1 or later.
- A `Tick` in cycle N never pops an entry pushed in cycle N, unless `Count` was 0 … this case cannot occur: with an empty queue nothing is popped.
- `Rejected` and `Turned` are registered, high for exactly one cycle, and not sticky.
- Back-to-back ticks pop one entry per cycle.
- No combinational path from inputs to outputs.

## Structure
- **Shared package `snake_pkg`:**
  - direction constants `DIR_UP` = 0, `DIR_DOWN` = 1, `DIR_LEFT` = 2, `DIR_RIGHT` = 3
  - 2-bit direction typedef
  - `opposite()` helper, reused by the collision and rendering logic
- **Sub-module `turn_fifo`:**
  - generic DEPTH × 2-bit synchronous FIFO
  - exposes push, pop, head, tail, count, full, empty
- **Top level** contains the priority encoder, the accept logic and the `Direction` / `Turned` / `Rejected` registers.

## Test plan
- **Reset.** Hold `Reset_n` low 3 cycles with `BtnUp` pulsing → `Direction` = 3, `Count` = 0, `Turned` = 0, `Rejected` = 0 throughout.
- **Two queued turns.** From `Direction` = RIGHT: `BtnUp` at cycle 10, `BtnLeft` at cycle 12 → `Count` = 2. `Tick` at cycle 20 → `Direction` = UP at cycle 21 with `Turned` = 1. `Tick` at cycle 30 → `Direction` = LEFT, `Count` = 0.
- **Reversal and duplicate rejects.** From RIGHT: `BtnLeft` → `Rejected` pulse, `Count` = 0. Then `BtnUp`, `BtnUp` → second press rejected, `Count` = 1. Then `BtnDown` → rejected (reverse of tail UP).
- **Full queue with simultaneous `Tick`.** With `DEPTH` = 2, queue holds [UP, LEFT]. `BtnDown` alone → rejected. `BtnDown` with `Tick` in the same cycle → accepted; `Direction` = UP, queue = [LEFT, DOWN], `Count` = 2.
- **Simultaneous buttons.** `BtnDown` and `BtnLeft` in the same cycle, from RIGHT → DOWN queued, LEFT ignored, no `Rejected`.
- **`Clear` mid-operation.** `Clear` with `Count` = 2 and a coincident `Tick` → next cycle `Count` = 0, `Direction` = 3, `Turned` = 0.
